inst_buffer: RTL and testbench
==============================

// Module: inst_buffer
// PURPOSE
//  Dual-issue instruction queue between IF and ID. Holds fetched {pc, inst, fetch exception} bundles.
//  Up to 2 pushes per cycle from fetch; up to 2 in-order pops per cycle into the decoder pair
//  (2RI12/2R/3R/... format decoders). Decouples fetch from decode stalls; flushed on redirect.
// PARAMETERS
//  DEPTH   8   entry count; power of two, >= 4
//  PTR_W   3   log2(DEPTH); count register is PTR_W+1 bits
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  flush          in   1   pipeline redirect (branch mispredict / exception / ertn); clears queue
//  if_valid       in   2   per-slot push valid from fetch; bit0 = older instruction
//  if_pc          in   64  {slot1_pc, slot0_pc}
//  if_inst        in   64  {slot1_inst, slot0_inst}
//  if_is_exc      in   2   per-slot fetch exception flag (ADEF, TLB refill/PIF/PPI)
//  if_exc_cause   in   14  {slot1_cause, slot0_cause}, 7 bits each, exception code encoding
//  if_ready       out  1   1 when >= 2 entries free (registered count only)
//  id_valid       out  2   bit0: head entry present; bit1: head+1 also present
//  id_pc          out  64  {head+1 pc, head pc}; 0 for an invalid slot
//  id_inst        out  64  {head+1 inst, head inst}; 0 for an invalid slot
//  id_is_exc      out  2   exception flag per output slot; 0 for an invalid slot
//  id_exc_cause   out  14  cause per output slot; 0 for an invalid slot
//  id_accept      in   2   decoder consumes slots this cycle; thermometer 00/01/11
// BEHAVIOUR
//  Storage: circular array, head (rd_ptr), tail (wr_ptr), count; pointers wrap modulo DEPTH.
//  Reset (async, rst_n=0): rd_ptr=wr_ptr=0, count=0, storage zeroed; outputs id_valid=0,
//   id_pc/id_inst/id_is_exc/id_exc_cause=0, if_ready=1. Applies immediately, even mid-burst.
//  Push: push_en = if_valid & {2{if_ready}}. Valid slots are written in order at wr_ptr,
//   wr_ptr+1, skipping invalid ones (10 writes only slot1 at wr_ptr). push_num = popcount(0..2).
//   if_valid asserted while if_ready=0: data dropped; fetch must hold it (no push).
//  Pop: pop_num = (id_accept[0]&id_valid[0]) ? ((id_accept[1]&id_valid[1]) ? 2 : 1) : 0.
//   id_accept 10 or accept of invalid slot is ignored (counts as 0 for that slot).
//  Update each cycle: wr_ptr += push_num; rd_ptr += pop_num; count += push_num - pop_num.
//  Latency: pushed entry visible on id_* the cycle after the push edge; no same-cycle bypass.
//  Outputs combinational from registered storage/count: id_valid[0]=(count>=1),
//   id_valid[1]=(count>=2); data from entries rd_ptr, rd_ptr+1 (wrapping), masked to 0 if invalid.
//  if_ready = (DEPTH - count >= 2), from registered count; a same-cycle pop does NOT raise it.
//  Full: count=DEPTH-1 or DEPTH -> if_ready=0. Empty: count=0 -> id_valid=00, pops ignored.
//  Simultaneous push+pop: both take effect; count never exceeds DEPTH or goes negative.
//  Flush: highest priority; at the edge rd_ptr=wr_ptr=0, count=0, same-cycle push/pop discarded;
//   next cycle id_valid=00, if_ready=1. Storage contents need not be cleared.
//  Exception bundles are queued like normal instructions; no special handling in this block.
// TESTING
//  1 Reset: rst_n=0 mid-stream with count=5 -> id_valid=00, if_ready=1 immediately; after
//    release push pc 0x1c000000/0x1c000004 -> next cycle id_valid=11 with those pcs in order.
//  2 Fill: id_accept=00, push 2/cycle -> if_ready drops after count=8 (4 pushes); 5th pair
//    offered while if_ready=0 is not stored; count stays 8.
//  3 Wrap: 20 cycles push 11 / accept 11 with incrementing pcs -> pcs out strictly +4 in order
//    across pointer wrap, no gaps, no duplicates, count constant.
//  4 Partial: push 10 (slot1 pc 0x1c000010) then accept 01 on count=3 -> head advances by 1;
//    accept 10 -> no pop; id_valid[1]=0 when count=1 even if id_accept=11 (pop_num=1).
//  5 Flush: count=6, same cycle flush=1, push 11, accept 11 -> next cycle count=0, id_valid=00,
//    id_pc=0, if_ready=1; following push appears at head with correct pc.
//  6 Exception passthrough: push slot0 is_exc=1 cause=7'h08 (ADEF) -> id_is_exc[0]=1,
//    id_exc_cause[6:0]=7'h08 next cycle; slot1 clean -> id_is_exc[1]=0.

Source files
------------

// File: rtl/inst_buffer_if.sv
// inst_buffer_if: fetch-side push and decode-side pop bundle for the dual-issue instruction queue.
interface inst_buffer_if;
   logic        flush;
   logic [1:0]  if_valid;
   logic [63:0] if_pc;
   logic [63:0] if_inst;
   logic [1:0]  if_is_exc;
   logic [13:0] if_exc_cause;
   logic        if_ready;
   logic [1:0]  id_valid;
   logic [63:0] id_pc;
   logic [63:0] id_inst;
   logic [1:0]  id_is_exc;
   logic [13:0] id_exc_cause;
   logic [1:0]  id_accept;
   modport master (
      output flush, if_valid, if_pc, if_inst, if_is_exc, if_exc_cause, id_accept,
      input  if_ready, id_valid, id_pc, id_inst, id_is_exc, id_exc_cause
   );
   modport slave (
      input  flush, if_valid, if_pc, if_inst, if_is_exc, if_exc_cause, id_accept,
      output if_ready, id_valid, id_pc, id_inst, id_is_exc, id_exc_cause
   );
endinterface

// File: rtl/inst_buffer.sv
// inst_buffer: circular dual-push / dual-pop queue of {pc, inst, fetch exception} between IF and ID.
module inst_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input logic         clk,
   input logic         rst_n,
   inst_buffer_if.slave bus
);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        is_exc;
      logic [6:0]  cause;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q, rd_nxt;
   logic [PTR_W:0]     count_q;
   logic               ready;
   logic [1:0]         valid, push_en, push_num, pop_num;
   entry_t             in0, in1, h0, h1;

   assign ready    = count_q <= (PTR_W+1)'(DEPTH-2);
   assign valid    = {count_q >= (PTR_W+1)'(2), count_q != '0};
   assign push_en  = bus.if_valid & {2{ready}};
   assign push_num = {1'b0, push_en[0]} + {1'b0, push_en[1]};
   // id_accept is a thermometer; a slot only pops if it and every older slot are valid and accepted
   assign pop_num  = (bus.id_accept[0] & valid[0]) ? ((bus.id_accept[1] & valid[1]) ? 2'd2 : 2'd1) : 2'd0;
   assign rd_nxt   = rd_ptr_q + PTR_W'(1);

   assign in0 = {bus.if_pc[31:0], bus.if_inst[31:0], bus.if_is_exc[0], bus.if_exc_cause[6:0]};
   assign in1 = {bus.if_pc[63:32], bus.if_inst[63:32], bus.if_is_exc[1], bus.if_exc_cause[13:7]};
   assign h0  = valid[0] ? mem_q[rd_ptr_q] : '0;
   assign h1  = valid[1] ? mem_q[rd_nxt] : '0;

   assign bus.if_ready     = ready;
   assign bus.id_valid     = valid;
   assign bus.id_pc        = {h1.pc, h0.pc};
   assign bus.id_inst      = {h1.inst, h0.inst};
   assign bus.id_is_exc    = {h1.is_exc, h0.is_exc};
   assign bus.id_exc_cause = {h1.cause, h0.cause};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (bus.flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // slot1 lands directly at the tail when slot0 is not pushed
         if (push_en[0]) mem_q[wr_ptr_q] <= in0;
         if (push_en[1]) mem_q[wr_ptr_q + PTR_W'(push_en[0])] <= in1;
         wr_ptr_q <= wr_ptr_q + PTR_W'(push_num);
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop_num);
         count_q  <= count_q + (PTR_W+1)'(push_num) - (PTR_W+1)'(pop_num);
      end
   end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed stimulus with a queue scoreboard checked by an independent negedge monitor.
module tb_inst_buffer;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        is_exc;
      logic [6:0]  cause;
   } ent_t;

   logic clk = 0;
   logic rst_n = 0;
   inst_buffer_if bus();
   inst_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_fail = 0;
   ent_t sb[$];
   ent_t pend[$];
   logic [31:0] pc;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1; sb mirrors what the queue holds at this point.
   task automatic cyc(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                      input logic [1:0] acc, input logic fl = 1'b0,
                      input logic [1:0] exc = 2'b00, input logic [6:0] c0 = 7'h00);
      bit rdy;
      bus.if_valid     = v;
      bus.if_pc        = {pc1, pc0};
      bus.if_inst      = {~pc1, ~pc0};
      bus.if_is_exc    = exc;
      bus.if_exc_cause = {7'h00, c0};
      bus.id_accept    = acc;
      bus.flush        = fl;
      rdy = sb.size() <= DEPTH - 2;
      pend.delete();
      if (rdy && !fl) begin
         if (v[0]) pend.push_back('{pc0, ~pc0, exc[0], c0});
         if (v[1]) pend.push_back('{pc1, ~pc1, exc[1], 7'h00});
      end
      @(posedge clk);
      #1;
      foreach (pend[i]) sb.push_back(pend[i]);
      bus.if_valid  = 2'b00;
      bus.id_accept = 2'b00;
      bus.flush     = 1'b0;
   endtask

   task automatic drain();
      while (sb.size() != 0) cyc(2'b00, 0, 0, 2'b11);
   endtask

   always @(negedge clk) begin
      ent_t e0, e1;
      int   n;
      if (rst_n) begin
         e0 = sb.size() >= 1 ? sb[0] : '0;
         e1 = sb.size() >= 2 ? sb[1] : '0;
         chk("if_ready", {71'd0, bus.if_ready}, {71'd0, sb.size() <= DEPTH - 2});
         chk("id_valid", {70'd0, bus.id_valid}, {70'd0, sb.size() >= 2, sb.size() >= 1});
         chk("slot0", {bus.id_pc[31:0], bus.id_inst[31:0], bus.id_is_exc[0], bus.id_exc_cause[6:0]}, e0);
         chk("slot1", {bus.id_pc[63:32], bus.id_inst[63:32], bus.id_is_exc[1], bus.id_exc_cause[13:7]}, e1);
         if (bus.flush) sb.delete();
         else begin
            n = (bus.id_accept[0] && sb.size() >= 1) ? ((bus.id_accept[1] && sb.size() >= 2) ? 2 : 1) : 0;
            repeat (n) void'(sb.pop_front());
         end
      end
   end

   initial begin
      bus.if_valid = 0; bus.if_pc = 0; bus.if_inst = 0; bus.if_is_exc = 0;
      bus.if_exc_cause = 0; bus.id_accept = 0; bus.flush = 0;
      @(posedge clk); #1;
      chk("rst_valid", {70'd0, bus.id_valid}, 72'd0);
      chk("rst_ready", {71'd0, bus.if_ready}, 72'd1);
      chk("rst_pc", {8'd0, bus.id_pc}, 72'd0);
      rst_n = 1;
      // reset asserted mid-stream with five entries held
      cyc(2'b11, 32'h1c000000, 32'h1c000004, 2'b00);
      chk("t1_pc", {8'd0, bus.id_pc}, {8'd0, 64'h1c000004_1c000000});
      cyc(2'b11, 32'h1c000008, 32'h1c00000c, 2'b00);
      cyc(2'b01, 32'h1c000010, 32'h0, 2'b00);
      rst_n = 0;
      #1;
      chk("async_rst_valid", {70'd0, bus.id_valid}, 72'd0);
      chk("async_rst_ready", {71'd0, bus.if_ready}, 72'd1);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1;
      cyc(2'b11, 32'h1c000000, 32'h1c000004, 2'b00);
      chk("t1_valid", {70'd0, bus.id_valid}, 72'd3);
      chk("t1_pc_again", {8'd0, bus.id_pc}, {8'd0, 64'h1c000004_1c000000});
      drain();
      // fill to eight, then offer a fifth pair while not ready
      pc = 32'h1c001000;
      for (int i = 0; i < 4; i++) begin
         cyc(2'b11, pc, pc + 4, 2'b00);
         pc += 8;
      end
      chk("full_ready", {71'd0, bus.if_ready}, 72'd0);
      cyc(2'b11, pc, pc + 4, 2'b00);
      chk("full_hold_ready", {71'd0, bus.if_ready}, 72'd0);
      chk("full_head_pc", {8'd0, bus.id_pc}, {8'd0, 64'h1c001004_1c001000});
      drain();
      chk("full_drained", {70'd0, bus.id_valid}, 72'd0);
      // steady push 11 / accept 11 across pointer wrap
      pc = 32'h1c002000;
      cyc(2'b11, pc, pc + 4, 2'b00);
      pc += 8;
      for (int i = 0; i < 20; i++) begin
         cyc(2'b11, pc, pc + 4, 2'b11);
         pc += 8;
      end
      drain();
      // partial push and partial/illegal accepts
      cyc(2'b11, 32'h1c000100, 32'h1c000104, 2'b00);
      cyc(2'b10, 32'hdead0000, 32'h1c000010, 2'b00);
      chk("part_pc", {8'd0, bus.id_pc}, {8'd0, 64'h1c000104_1c000100});
      cyc(2'b00, 0, 0, 2'b01);
      chk("part_pop1", {8'd0, bus.id_pc}, {8'd0, 64'h1c000010_1c000104});
      cyc(2'b00, 0, 0, 2'b10);
      chk("part_acc10", {8'd0, bus.id_pc}, {8'd0, 64'h1c000010_1c000104});
      cyc(2'b00, 0, 0, 2'b01);
      chk("part_cnt1_valid", {70'd0, bus.id_valid}, 72'd1);
      chk("part_cnt1_pc", {8'd0, bus.id_pc}, {8'd0, 64'h00000000_1c000010});
      cyc(2'b00, 0, 0, 2'b11);
      chk("part_empty", {70'd0, bus.id_valid}, 72'd0);
      // flush with concurrent push and pop at count six
      pc = 32'h1c003000;
      for (int i = 0; i < 3; i++) begin
         cyc(2'b11, pc, pc + 4, 2'b00);
         pc += 8;
      end
      cyc(2'b11, pc, pc + 4, 2'b11, 1'b1);
      chk("flush_valid", {70'd0, bus.id_valid}, 72'd0);
      chk("flush_pc", {8'd0, bus.id_pc}, 72'd0);
      chk("flush_ready", {71'd0, bus.if_ready}, 72'd1);
      cyc(2'b11, 32'h1c000200, 32'h1c000204, 2'b00);
      chk("flush_next_pc", {8'd0, bus.id_pc}, {8'd0, 64'h1c000204_1c000200});
      drain();
      // fetch exception on slot0 only
      cyc(2'b11, 32'h1c000300, 32'h1c000304, 2'b00, 1'b0, 2'b01, 7'h08);
      chk("exc_flag", {70'd0, bus.id_is_exc}, 72'd1);
      chk("exc_cause", {58'd0, bus.id_exc_cause}, 72'h08);
      drain();
      cyc(2'b00, 0, 0, 2'b00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
